store_write_buffer: RTL and testbench

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/store_write_buffer.sv | 90 +++++++++
 tb/tb_store_write_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer: in-order FIFO of CPU stores draining to DMEM through a valid/ready port,
// with youngest-match load forwarding from the buffered entries.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    input  logic                     cpu_we,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_stall,
    output logic [31:0]              mem_raddr,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              mem_waddr,
    output logic [31:0]              mem_wdata,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          enq;
    logic          deq;
    logic [PW-1:0] fwd_idx;

    always_comb begin
        full    = (count_q == FULL_CNT);
        enq     = cpu_we & ~full;
        deq     = (count_q != '0) & mem_wready;
        head_d  = deq ? head_q + PW'(1) : head_q;
        tail_d  = enq ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match (youngest store) wins; slots past occupancy are ignored.
    always_comb begin
        cpu_rdata = mem_rdata;
        fwd_idx   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[fwd_idx][31:2] == cpu_addr[31:2])) begin
                cpu_rdata = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            addr_q[tail_q] <= cpu_addr;
            data_q[tail_q] <= cpu_wdata;
        end
    end

    assign cpu_stall  = cpu_we & full;
    assign mem_raddr  = cpu_addr;
    assign mem_waddr  = addr_q[head_q];
    assign mem_wdata  = data_q[head_q];
    assign mem_wvalid = (count_q != '0);
    assign count      = count_q;
    assign empty      = (count_q == '0);

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer (DEPTH=4): drain, fill/stall,
// forwarding, simultaneous enq/deq, wrap-around ordering and asynchronous reset.
module tb_store_write_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [2:0]  count;
    logic        empty;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    store_write_buffer #(.DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .count      (count),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] exp_addr [5];
    logic [31:0] exp_data [5];
    logic [15:0] rdy_pat;
    int unsigned sent;
    int unsigned got;
    logic        accepted;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        cpu_we     = 1'b0;
        mem_rdata  = '0;
        mem_wready = 1'b0;
        #3;
        check("rst_count",  32'(count), 32'd0);
        check("rst_empty",  32'(empty), 32'd1);
        check("rst_wvalid", 32'(mem_wvalid), 32'd0);
        cpu_we = 1'b1;
        #1;
        check("rst_stall",  32'(cpu_stall), 32'd0);
        cpu_we = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // single store written straight through
        mem_wready = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 32'h10;
        cpu_wdata  = 32'hAAAA5555;
        #1;
        check("raddr_eq", mem_raddr, 32'h10);
        tick();
        cpu_we = 1'b0;
        #1;
        check("single_wvalid", 32'(mem_wvalid), 32'd1);
        check("single_waddr",  mem_waddr, 32'h10);
        check("single_wdata",  mem_wdata, 32'hAAAA5555);
        tick();
        check("single_empty",  32'(empty), 32'd1);

        // fill then stall
        mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_we    = 1'b1;
            cpu_addr  = 32'(4 * i);
            cpu_wdata = 32'h100 + 32'(i);
            tick();
        end
        cpu_addr  = 32'h40;
        cpu_wdata = 32'h555;
        #1;
        check("fill_count", 32'(count), 32'd4);
        check("fill_stall", 32'(cpu_stall), 32'd1);
        tick();
        check("stall_count", 32'(count), 32'd4);
        check("stall_hold",  32'(cpu_stall), 32'd1);
        check("fill_head_addr", mem_waddr, 32'h0);
        check("fill_head_data", mem_wdata, 32'h100);
        mem_wready = 1'b1;
        tick();
        check("full_deq_count", 32'(count), 32'd3);
        check("full_deq_stall", 32'(cpu_stall), 32'd0);
        mem_wready = 1'b0;
        tick();
        check("fifth_count", 32'(count), 32'd4);
        cpu_we     = 1'b0;
        mem_wready = 1'b1;
        exp_addr[0] = 32'h4;  exp_data[0] = 32'h101;
        exp_addr[1] = 32'h8;  exp_data[1] = 32'h102;
        exp_addr[2] = 32'hC;  exp_data[2] = 32'h103;
        exp_addr[3] = 32'h40; exp_data[3] = 32'h555;
        #1;
        for (int j = 0; j < 4; j++) begin
            check("drain_addr", mem_waddr, exp_addr[j]);
            check("drain_data", mem_wdata, exp_data[j]);
            tick();
        end
        check("drain_empty", 32'(empty), 32'd1);

        // forwarding: youngest match wins, word granularity
        mem_wready = 1'b0;
        cpu_we     = 1'b1;
        cpu_addr   = 32'h20;
        cpu_wdata  = 32'h1;
        tick();
        cpu_wdata  = 32'h2;
        tick();
        cpu_we    = 1'b0;
        cpu_addr  = 32'h22;
        mem_rdata = 32'hDEAD;
        #1;
        check("fwd_young", cpu_rdata, 32'h2);
        cpu_addr  = 32'h24;
        mem_rdata = 32'h7;
        #1;
        check("fwd_miss", cpu_rdata, 32'h7);
        mem_wready = 1'b1;
        tick();
        cpu_addr  = 32'h20;
        mem_rdata = 32'h99;
        #1;
        check("fwd_head_accept", cpu_rdata, 32'h2);
        tick();
        check("fwd_stale", cpu_rdata, 32'h99);

        // simultaneous enqueue and dequeue
        mem_wready = 1'b0;
        cpu_we     = 1'b1;
        cpu_addr   = 32'h30;
        cpu_wdata  = 32'hA;
        tick();
        cpu_addr   = 32'h34;
        cpu_wdata  = 32'hB;
        tick();
        check("sim_pre_count", 32'(count), 32'd2);
        cpu_addr   = 32'h38;
        cpu_wdata  = 32'hC;
        mem_wready = 1'b1;
        tick();
        cpu_we = 1'b0;
        #1;
        check("sim_count", 32'(count), 32'd2);
        check("sim_head_addr", mem_waddr, 32'h34);
        check("sim_head_data", mem_wdata, 32'hB);
        tick();
        check("sim_next_addr", mem_waddr, 32'h38);
        check("sim_next_data", mem_wdata, 32'hC);
        check("sim_next_count", 32'(count), 32'd1);
        tick();
        check("sim_empty", 32'(empty), 32'd1);

        // wrap-around with irregular wready; scoreboard on store order
        rdy_pat = 16'b0110_1101_0011_1010;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            cpu_we     = (sent < 10);
            cpu_addr   = 32'h100 + 32'(4 * sent);
            cpu_wdata  = 32'hC0DE0000 + 32'(sent);
            mem_wready = rdy_pat[cyc % 16];
            #1;
            check("wrap_count", 32'(count), 32'(sent - got));
            if (mem_wvalid && mem_wready) begin
                check("wrap_addr", mem_waddr, 32'h100 + 32'(4 * got));
                check("wrap_data", mem_wdata, 32'hC0DE0000 + 32'(got));
                got++;
            end
            accepted = cpu_we && !cpu_stall;
            tick();
            if (accepted) sent++;
        end
        cpu_we = 1'b0;
        check("wrap_sent", 32'(sent), 32'd10);
        check("wrap_got",  32'(got),  32'd10);
        mem_wready = 1'b1;
        tick();
        check("wrap_no_dup", 32'(mem_wvalid), 32'd0);

        // asynchronous reset with three stores pending
        mem_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_we    = 1'b1;
            cpu_addr  = 32'h200 + 32'(4 * i);
            cpu_wdata = 32'h50 + 32'(i);
            tick();
        end
        check("arst_pre_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_wvalid", 32'(mem_wvalid), 32'd0);
        check("arst_count",  32'(count), 32'd0);
        check("arst_empty",  32'(empty), 32'd1);
        check("arst_stall",  32'(cpu_stall), 32'd0);
        tick();
        reset      = 1'b0;
        cpu_we     = 1'b0;
        mem_wready = 1'b1;
        tick();
        check("arst_no_write", 32'(mem_wvalid), 32'd0);
        cpu_we    = 1'b1;
        cpu_addr  = 32'h300;
        cpu_wdata = 32'h77;
        tick();
        cpu_we = 1'b0;
        #1;
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_addr",  mem_waddr, 32'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
